button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage between the raw push-button pin and the `timer` block. It synchronises the asynchronous button and debounces both edges with a counter-based FSM. It emits single-cycle press, release and long-press strobes plus a clean debounced level. `timer` consumes `press_pulse` on its button input, so each physical press produces exactly one event.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable synchronised samples required to accept an edge; 20 ms at 100 MHz; must be ≥ 1.
- `LONG_PRESS_CYCLES`, default 100_000_000: cycles after `press_pulse` with the button held before `long_pulse` fires; must be > `DEBOUNCE_CYCLES`.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `button`  input  1  raw, bouncy, asynchronous button; 1 = pressed.
- `level`  output  1  debounced button state.
- `press_pulse`  output  1  one-cycle strobe on an accepted press.
- `release_pulse`  output  1  one-cycle strobe on an accepted release.
- `long_pulse`  output  1  one-cycle strobe; at most once per press.

## Operation
- Synchroniser: two flops `button` → s1 → s2. The FSM uses only s2 (`btn_s`).
- One shared counter, width $clog2(LONG_PRESS_CYCLES+1), plus a `long_done` flag.
- States:
  - IDLE: counter = 0. `btn_s`=1 → PRESS_WAIT with counter = 1.
  - PRESS_WAIT: `btn_s`=0 → IDLE (bounce rejected, no output). Otherwise, when the counter reaches `DEBOUNCE_CYCLES`: → PRESSED, assert `press_pulse`, set `level`=1, clear the counter and `long_done`. Else increment.
  - PRESSED: `btn_s`=1 increments the counter. When it reaches `LONG_PRESS_CYCLES`, assert `long_pulse`, set `long_done`, → HELD. `btn_s`=0 → RELEASE_WAIT; the hold count is saved in a separate hold register, and the counter is reused for release debounce, set to 1.
  - HELD: `btn_s`=0 → RELEASE_WAIT, counter = 1. Otherwise stay.
  - RELEASE_WAIT: `btn_s`=1 (release bounce) returns to HELD if `long_done`, else to PRESSED with the counter restored from the hold register. No strobe fires on this return. When the counter reaches `DEBOUNCE_CYCLES` with `btn_s`=0: → IDLE, assert `release_pulse`, set `level`=0.
- Strobes are registered and high for exactly one cycle; at most one strobe is high in any cycle.
- `level` changes in the same cycle as `press_pulse` and `release_pulse`.
- Counters saturate; no wrap-around is reachable in any state.

## Timing
- Reset values: s1, s2, counter, hold register and `long_done` = 0; state = IDLE; `level`, `press_pulse`, `release_pulse`, `long_pulse` = 0. Reset takes effect immediately, without waiting for `clk`.
- Reset mid-operation aborts any debounce or hold with no strobe. If the button is still held after `rst` falls, the press is re-debounced and a new `press_pulse` fires.
- Press latency: `button` is first sampled high at edge k. `press_pulse` is high in the cycle after edge k+1+`DEBOUNCE_CYCLES`, i.e. after edge k+5 when `DEBOUNCE_CYCLES`=4.
- Release latency is identical, measured from the first edge sampling `button` low.
- Long press: `long_pulse` rises exactly `LONG_PRESS_CYCLES` cycles after `press_pulse`, counting only cycles in which `btn_s`=1.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `level` or produces a strobe.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=10 and a 20 ns clock.
- Reset: hold `rst`=1 with `button` toggling. All outputs stay 0. Release `rst` with `button`=0: outputs stay 0.
- Clean press: `button` rises and is first sampled at edge k, held 20 cycles, then released. Required response:
  - `press_pulse`=1 for one cycle after edge k+5, with `level`=1 from then on.
  - `long_pulse`=1 for one cycle 10 cycles later.
  - `release_pulse` 6 edges after the first low sample, with `level`=0.
- Bounce rejection: pulses 1-0-1-0 of 2 cycles each, then 3 cycles high, then 0. No strobe fires and `level` stays 0.
- Release bounce: after `press_pulse`, drop `button` for 2 cycles at hold count 3, then hold. `long_pulse` fires 7 further high cycles later, i.e. the count resumes at 3. No `release_pulse` fires.
- Short press: hold 8 cycles past `press_pulse`, then release. `release_pulse` fires; `long_pulse` never fires.
- Reset mid-hold: assert `rst` 3 cycles after `press_pulse` with `button` still 1. `level` drops to 0 immediately. After `rst` deasserts, a fresh `press_pulse` fires 6 edges later.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle.
// Groups the raw button input with the debounced level and the three event
// strobes so the conditioner and its consumer share one connection point.
//   button        : raw, asynchronous push-button level (1 = pressed)
//   level         : debounced button state
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//   long_pulse    : one-cycle strobe after a long hold (once per press)
interface button_conditioner_if;
  logic button;
  logic level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  // Stimulus / consumer side: drives the raw button, observes the events.
  modport master (
    output button,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  // Conditioner side.
  modport slave (
    input  button,
    output level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser followed by a counter-based
// debounce FSM that accepts both edges and emits registered one-cycle
// press / release / long-press strobes plus a clean debounced level.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bc  : button_conditioner_if.slave (button in; level and strobes out)
// Parameters:
//   DEBOUNCE_CYCLES   : consecutive stable synchronised samples to accept an edge (>= 1)
//   LONG_PRESS_CYCLES : held cycles after press_pulse before long_pulse (> DEBOUNCE_CYCLES)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  button_conditioner_if.slave bc
);

  localparam int unsigned CW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_PRESS_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HELD,
    RELEASE_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  logic          btn_s;
  logic [CW-1:0] cnt_inc;
  logic          deb_hit;
  logic          long_hit;

  assign btn_s = s2_q;

  // Saturating increment. The counter holds the number of samples already
  // taken, so an edge is accepted on the sample that brings it to the limit.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign deb_hit  = (cnt_inc >= DEB_C);
  assign long_hit = (cnt_inc >= LONG_C);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      s1_q        <= bc.button;
      s2_q        <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (deb_hit) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          // Park the hold count; the counter is borrowed for release debounce.
          state_d = RELEASE_WAIT;
          hold_d  = cnt_q;
          cnt_d   = CW'(1);
        end else if (long_hit) begin
          state_d     = HELD;
          long_done_d = 1'b1;
          cnt_d       = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: resume the interrupted hold without any strobe.
          state_d = long_done_q ? HELD : PRESSED;
          cnt_d   = hold_q;
        end else if (deb_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic (strobes and level are registered)
  always_comb begin
    press_d   = (state_q == PRESS_WAIT)   &&  btn_s && deb_hit;
    release_d = (state_q == RELEASE_WAIT) && !btn_s && deb_hit;
    long_d    = (state_q == PRESSED)      &&  btn_s && long_hit;
    level_d   = level_q;
    if (press_d) begin
      level_d = 1'b1;
    end else if (release_d) begin
      level_d = 1'b0;
    end
  end

  assign bc.level         = level_q;
  assign bc.press_pulse   = press_q;
  assign bc.release_pulse = release_q;
  assign bc.long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=10. Outputs are compared as {level, press, release, long}.
module tb_button_conditioner;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fails;

  button_conditioner_if bc_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bc  (bc_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bc_if.level, bc_if.press_pulse, bc_if.release_pulse, bc_if.long_pulse};
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Button first sampled high at the next edge k; press_pulse after edge k+5.
  task automatic do_press(input string tag);
    bc_if.button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_press_wait"}, 4'b0000);
    end
    tick();
    chk({tag, "_press"}, 4'b1100);
  endtask

  // Button first sampled low at the next edge m; release_pulse after edge m+5.
  task automatic do_release(input string tag);
    bc_if.button = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_release_wait"}, 4'b1000);
    end
    tick();
    chk({tag, "_release"}, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_idle"}, 4'b0000);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b1;
    bc_if.button = 1'b0;

    // Reset with a toggling button: outputs must stay low.
    #1;
    chk("reset_initial", 4'b0000);
    for (int i = 0; i < 6; i++) begin
      bc_if.button = ~bc_if.button;
      tick();
      chk("reset_toggle", 4'b0000);
    end
    bc_if.button = 1'b0;
    rst          = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_idle", 4'b0000);
    end

    // Clean press held 20 sampled cycles, long press, then release.
    do_press("clean");
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("clean_pressed", 4'b1000);
    end
    tick();
    chk("clean_long", 4'b1001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clean_held", 4'b1000);
    end
    do_release("clean");

    // Bounce rejection: 1-0-1-0 of two cycles each, then three high, then low.
    for (int i = 0; i < 2; i++) begin
      bc_if.button = 1'b1;
      repeat (2) begin
        tick();
        chk("bounce_hi", 4'b0000);
      end
      bc_if.button = 1'b0;
      repeat (2) begin
        tick();
        chk("bounce_lo", 4'b0000);
      end
    end
    bc_if.button = 1'b1;
    repeat (3) begin
      tick();
      chk("bounce_hi3", 4'b0000);
    end
    bc_if.button = 1'b0;
    repeat (8) begin
      tick();
      chk("bounce_settle", 4'b0000);
    end

    // Release bounce at hold count 3: long press resumes from 3 (7 more cycles).
    do_press("rb");
    tick();
    chk("rb_hold1", 4'b1000);
    bc_if.button = 1'b0;
    repeat (2) begin
      tick();
      chk("rb_drop", 4'b1000);
    end
    bc_if.button = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rb_resume", 4'b1000);
    end
    tick();
    chk("rb_long", 4'b1001);
    repeat (3) begin
      tick();
      chk("rb_held", 4'b1000);
    end
    do_release("rb");

    // Short press: eight synchronised high cycles after press_pulse, no long.
    do_press("short");
    repeat (6) begin
      tick();
      chk("short_hold", 4'b1000);
    end
    do_release("short");
    repeat (12) begin
      tick();
      chk("short_no_long", 4'b0000);
    end

    // Reset mid-hold: level drops at once, then the held button re-debounces.
    do_press("rmid");
    repeat (3) begin
      tick();
      chk("rmid_hold", 4'b1000);
    end
    #5;
    rst = 1'b1;
    #1;
    chk("rmid_async_reset", 4'b0000);
    tick();
    chk("rmid_in_reset", 4'b0000);
    rst = 1'b0;
    do_press("rmid_again");
    tick();
    chk("rmid_again_hold", 4'b1000);
    do_release("rmid_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
